// File: rtl/cpu_debug_slave_vjtag_master_pkg.sv
// Shared types and constants for the virtual-JTAG scan driver
// of the CPU debug slave.
package cpu_debug_vjtag_pkg;

  localparam int DEF_DR_WIDTH = 38;
  localparam int DEF_IR_WIDTH = 2;

  localparam logic [1:0] IR_OCIMEM    = 2'b00;
  localparam logic [1:0] IR_TRACEMEM  = 2'b01;
  localparam logic [1:0] IR_BREAK     = 2'b10;
  localparam logic [1:0] IR_TRACECTRL = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UIR,
    S_CDR,
    S_SDR,
    S_UDR,
    S_RTI,
    S_RESP
  } state_e;

endpackage

// File: rtl/cpu_debug_slave_vjtag_master_if.sv
// Command/response handshake between a sequencer and the
// virtual-JTAG scan driver.
interface cpu_debug_slave_vjtag_master_if
  import cpu_debug_vjtag_pkg::*;
#(
  parameter int DR_WIDTH = DEF_DR_WIDTH,
  parameter int IR_WIDTH = DEF_IR_WIDTH
) ();

  logic                cmd_valid;
  logic                cmd_ready;
  logic [IR_WIDTH-1:0] cmd_ir;
  logic [DR_WIDTH-1:0] cmd_data;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DR_WIDTH-1:0] rsp_data;
  logic [IR_WIDTH-1:0] rsp_ir_out;
  logic                busy;

  modport master (
    output cmd_valid, cmd_ir, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_ir_out, busy
  );

  modport slave (
    input  cmd_valid, cmd_ir, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_ir_out, busy
  );

endinterface

// File: rtl/cpu_debug_slave_vjtag_tck_gen.sv
// Divided TCK generator: TCK_HALF clk low, TCK_HALF clk high,
// with strobes for the clk edges where TCK rises and falls.
module cpu_debug_slave_vjtag_tck_gen #(
  parameter int TCK_HALF = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  output logic tck_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = $clog2(2 * TCK_HALF);
  localparam logic [CW-1:0] HALF = CW'(TCK_HALF - 1);
  localparam logic [CW-1:0] LAST = CW'(2 * TCK_HALF - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tck_q, tck_d;

  always_comb begin
    rise_o = en_i && (cnt_q == HALF);
    fall_o = en_i && (cnt_q == LAST);
    cnt_d  = (!en_i || fall_o) ? '0 : cnt_q + 1'b1;
    tck_d  = en_i && (rise_o || (tck_q && !fall_o));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end

  assign tck_o = tck_q;

endmodule

// File: rtl/cpu_debug_slave_vjtag_master.sv
// Runs one UIR/CDR/SDR/UDR/RTI virtual-JTAG scan per command
// and returns the captured TDO word.
module cpu_debug_slave_vjtag_master
  import cpu_debug_vjtag_pkg::*;
#(
  parameter int DR_WIDTH   = DEF_DR_WIDTH,
  parameter int IR_WIDTH   = DEF_IR_WIDTH,
  parameter int TCK_HALF   = 2,
  parameter int RTI_CYCLES = 1
) (
  input  logic                clk,
  input  logic                reset,
  cpu_debug_slave_vjtag_master_if.slave bus,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic [IR_WIDTH-1:0] vji_ir_out,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int CW = $clog2(DR_WIDTH + RTI_CYCLES + 1);
  localparam logic [CW-1:0] SDR_LAST = CW'(DR_WIDTH - 1);
  localparam logic [CW-1:0] RTI_LAST = CW'(RTI_CYCLES - 1);

  state_e              state_q;
  logic [CW-1:0]       cnt_q;
  logic [DR_WIDTH-1:0] tx_q, rx_q;
  logic [IR_WIDTH-1:0] ir_in_q, ir_out_q;
  logic                tdi_q, uir_q, cdr_q, sdr_q, udr_q, rti_q;
  logic                cmd_ready_q, rsp_valid_q, busy_q;
  logic                scan_en, tck_rise, tck_fall;

  assign scan_en = (state_q != S_IDLE) && (state_q != S_RESP);

  cpu_debug_slave_vjtag_tck_gen #(
    .TCK_HALF (TCK_HALF)
  ) u_tck (
    .clk    (clk),
    .reset  (reset),
    .en_i   (scan_en),
    .tck_o  (vji_tck),
    .rise_o (tck_rise),
    .fall_o (tck_fall)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      ir_in_q     <= '0;
      ir_out_q    <= '0;
      tdi_q       <= 1'b0;
      uir_q       <= 1'b0;
      cdr_q       <= 1'b0;
      sdr_q       <= 1'b0;
      udr_q       <= 1'b0;
      rti_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            state_q     <= S_UIR;
            ir_in_q     <= bus.cmd_ir;
            tx_q        <= bus.cmd_data;
            uir_q       <= 1'b1;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        S_UIR: begin
          if (tck_rise) ir_out_q <= vji_ir_out;
          if (tck_fall) begin
            state_q <= S_CDR;
            uir_q   <= 1'b0;
            cdr_q   <= 1'b1;
          end
        end
        S_CDR: begin
          if (tck_fall) begin
            state_q <= S_SDR;
            cdr_q   <= 1'b0;
            sdr_q   <= 1'b1;
            tdi_q   <= tx_q[0];
            cnt_q   <= '0;
          end
        end
        S_SDR: begin
          if (tck_rise) rx_q <= {vji_tdo, rx_q[DR_WIDTH-1:1]};
          if (tck_fall) begin
            if (cnt_q == SDR_LAST) begin
              state_q <= S_UDR;
              sdr_q   <= 1'b0;
              udr_q   <= 1'b1;
              tdi_q   <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
              tx_q  <= {1'b0, tx_q[DR_WIDTH-1:1]};
              tdi_q <= tx_q[1];
            end
          end
        end
        S_UDR: begin
          if (tck_fall) begin
            state_q <= S_RTI;
            udr_q   <= 1'b0;
            rti_q   <= 1'b1;
            cnt_q   <= '0;
          end
        end
        S_RTI: begin
          if (tck_fall) begin
            if (cnt_q == RTI_LAST) begin
              state_q     <= S_RESP;
              rti_q       <= 1'b0;
              rsp_valid_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rx_q;
  assign bus.rsp_ir_out = ir_out_q;
  assign bus.busy       = busy_q;

  assign vji_tdi   = tdi_q;
  assign vji_ir_in = ir_in_q;
  assign vji_uir   = uir_q;
  assign vji_cdr   = cdr_q;
  assign vji_sdr   = sdr_q;
  assign vji_udr   = udr_q;
  assign vji_rti   = rti_q;

endmodule

// File: tb/tb_cpu_debug_slave_vjtag_master.sv
// Bench for the virtual-JTAG scan driver: default instance plus a
// fast-TCK / long-RTI instance, each talking to a slave model.
module tb_cpu_debug_slave_vjtag_master;
  import cpu_debug_vjtag_pkg::*;

  typedef struct {
    logic [37:0] data;
    logic [1:0]  ir;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb0[$];
  exp_t sb1[$];

  cpu_debug_slave_vjtag_master_if #(.DR_WIDTH(38), .IR_WIDTH(2)) if0 ();
  cpu_debug_slave_vjtag_master_if #(.DR_WIDTH(38), .IR_WIDTH(2)) if1 ();

  logic       tck0, tdi0, tdo0, uir0, cdr0, sdr0, udr0, rti0;
  logic [1:0] irin0, irout0, irresp0;
  logic       tck1, tdi1, tdo1, uir1, cdr1, sdr1, udr1, rti1;
  logic [1:0] irin1, irout1, irresp1;

  logic [37:0] sr0, pre0, sr1, pre1;
  int          rise_sdr0 = 0;
  int          rise_sdr1 = 0;

  cpu_debug_slave_vjtag_master u0 (
    .clk        (clk),
    .reset      (rst0),
    .bus        (if0),
    .vji_tck    (tck0),
    .vji_tdi    (tdi0),
    .vji_tdo    (tdo0),
    .vji_ir_in  (irin0),
    .vji_ir_out (irout0),
    .vji_uir    (uir0),
    .vji_cdr    (cdr0),
    .vji_sdr    (sdr0),
    .vji_udr    (udr0),
    .vji_rti    (rti0)
  );

  cpu_debug_slave_vjtag_master #(
    .TCK_HALF   (1),
    .RTI_CYCLES (3)
  ) u1 (
    .clk        (clk),
    .reset      (rst1),
    .bus        (if1),
    .vji_tck    (tck1),
    .vji_tdi    (tdi1),
    .vji_tdo    (tdo1),
    .vji_ir_in  (irin1),
    .vji_ir_out (irout1),
    .vji_uir    (uir1),
    .vji_cdr    (cdr1),
    .vji_sdr    (sdr1),
    .vji_udr    (udr1),
    .vji_rti    (rti1)
  );

  // Slave models: reload on the UIR rise, shift on every SDR rise.
  assign tdo0   = sr0[0];
  assign irout0 = uir0 ? irresp0 : 2'b00;
  always @(posedge tck0) begin
    if (uir0) begin
      sr0       <= pre0;
      rise_sdr0 <= 0;
    end else if (sdr0) begin
      sr0       <= {tdi0, sr0[37:1]};
      rise_sdr0 <= rise_sdr0 + 1;
    end
  end

  assign tdo1   = sr1[0];
  assign irout1 = uir1 ? irresp1 : 2'b00;
  always @(posedge tck1) begin
    if (uir1) begin
      sr1       <= pre1;
      rise_sdr1 <= 0;
    end else if (sdr1) begin
      sr1       <= {tdi1, sr1[37:1]};
      rise_sdr1 <= rise_sdr1 + 1;
    end
  end

  int bad0 = 0;
  int bad1 = 0;
  always @(negedge clk) begin
    if (if0.busy && !if0.rsp_valid &&
        $countones({uir0, cdr0, sdr0, udr0, rti0}) != 1)
      bad0 <= bad0 + 1;
    if (if1.busy && !if1.rsp_valid &&
        $countones({uir1, cdr1, sdr1, udr1, rti1}) != 1)
      bad1 <= bad1 + 1;
  end

  int   cyc1 = 0;
  int   last_rise1 = 0;
  int   per1 = 0;
  int   rti_cnt1 = 0;
  logic tck1_prev = 1'b0;
  always @(negedge clk) begin
    cyc1      <= cyc1 + 1;
    tck1_prev <= tck1;
    if (tck1 && !tck1_prev) begin
      per1       <= cyc1 - last_rise1;
      last_rise1 <= cyc1;
    end
    if (uir1) rti_cnt1 <= 0;
    else if (rti1) rti_cnt1 <= rti_cnt1 + 1;
  end

  // Called at a negedge with cmd_ready high; returns at the negedge
  // after the handshake edge.
  task automatic issue0(input logic [1:0] ir, input logic [37:0] data,
                        input logic [37:0] pre, input logic [1:0] irr,
                        input int lat);
    pre0    = pre;
    irresp0 = irr;
    sb0.push_back('{data: pre, ir: irr, lat: lat});
    if0.cmd_ir    = ir;
    if0.cmd_data  = data;
    if0.cmd_valid = 1'b1;
    @(negedge clk);
    if0.cmd_valid = 1'b0;
  endtask

  task automatic issue1(input logic [1:0] ir, input logic [37:0] data,
                        input logic [37:0] pre, input logic [1:0] irr,
                        input int lat);
    pre1    = pre;
    irresp1 = irr;
    sb1.push_back('{data: pre, ir: irr, lat: lat});
    if1.cmd_ir    = ir;
    if1.cmd_data  = data;
    if1.cmd_valid = 1'b1;
    @(negedge clk);
    if1.cmd_valid = 1'b0;
  endtask

  task automatic await0(output int lat);
    lat = 1;
    while (!if0.rsp_valid && lat < 400) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic await1(output int lat);
    lat = 1;
    while (!if1.rsp_valid && lat < 400) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic accept0();
    if0.rsp_ready = 1'b1;
    @(negedge clk);
    if0.rsp_ready = 1'b0;
  endtask

  task automatic accept1();
    if1.rsp_ready = 1'b1;
    @(negedge clk);
    if1.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst0 = 1'b1;
    rst1 = 1'b1;
    repeat (3) @(negedge clk);
    rst0 = 1'b0;
    rst1 = 1'b0;
    @(negedge clk);
    n_vec++;
    if (if0.cmd_ready !== 1'b1 || if0.busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hs: ready=%b busy=%b want 1 0",
               if0.cmd_ready, if0.busy);
    end
    n_vec++;
    if ({tck0, tdi0, irin0, uir0, cdr0, sdr0, udr0, rti0} !== 9'h0 ||
        if0.rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_vji0: vji=%b rsp_valid=%b want 0",
               {tck0, tdi0, irin0, uir0, cdr0, sdr0, udr0, rti0},
               if0.rsp_valid);
    end
    n_vec++;
    if ({tck1, tdi1, irin1, uir1, cdr1, sdr1, udr1, rti1} !== 9'h0 ||
        if1.rsp_valid !== 1'b0 || if1.cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_vji1: vji=%b rsp_valid=%b ready=%b want 0 0 1",
               {tck1, tdi1, irin1, uir1, cdr1, sdr1, udr1, rti1},
               if1.rsp_valid, if1.cmd_ready);
    end
  endtask

  task automatic test_basic();
    exp_t e;
    int   lat;
    issue0(2'b01, 38'h3F_0000_0001, 38'h2A_5A5A_5A5A, 2'b10, 169);
    n_vec++;
    if (irin0 !== 2'b01 || uir0 !== 1'b1 || tck0 !== 1'b0) begin
      n_err++;
      $display("FAIL uir_entry: ir_in=%b uir=%b tck=%b want 01 1 0",
               irin0, uir0, tck0);
    end
    await0(lat);
    e = sb0.pop_front();
    n_vec++;
    if (lat !== e.lat) begin
      n_err++;
      $display("FAIL latency: got %0d want %0d", lat, e.lat);
    end
    n_vec++;
    if (if0.rsp_data !== e.data) begin
      n_err++;
      $display("FAIL rsp_data: got %h want %h", if0.rsp_data, e.data);
    end
    n_vec++;
    if (if0.rsp_ir_out !== e.ir) begin
      n_err++;
      $display("FAIL rsp_ir_out: got %b want %b", if0.rsp_ir_out, e.ir);
    end
    n_vec++;
    if (sr0 !== 38'h3F_0000_0001) begin
      n_err++;
      $display("FAIL slave_sr: got %h want %h", sr0, 38'h3F_0000_0001);
    end
    n_vec++;
    if (rise_sdr0 !== 38) begin
      n_err++;
      $display("FAIL sdr_rises: got %0d want 38", rise_sdr0);
    end
    n_vec++;
    if (bad0 !== 0) begin
      n_err++;
      $display("FAIL one_hot_flags: got %0d bad cycles want 0", bad0);
    end
    accept0();
    repeat (5) @(negedge clk);
    n_vec++;
    if (if0.rsp_valid !== 1'b0 || if0.cmd_ready !== 1'b1 ||
        if0.rsp_ir_out !== 2'b10 || irin0 !== 2'b01) begin
      n_err++;
      $display("FAIL after_resp: v=%b rdy=%b irout=%b irin=%b want 0 1 10 01",
               if0.rsp_valid, if0.cmd_ready, if0.rsp_ir_out, irin0);
    end
  endtask

  task automatic test_backpressure();
    exp_t        e;
    int          lat;
    bit          ok;
    logic [37:0] d, p;
    d = {6'($urandom()), 32'($urandom())};
    p = {6'($urandom()), 32'($urandom())};
    issue0(2'b11, d, p, 2'b01, 169);
    await0(lat);
    e = sb0.pop_front();
    n_vec++;
    if (lat !== e.lat) begin
      n_err++;
      $display("FAIL bp_latency: got %0d want %0d", lat, e.lat);
    end
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        if0.cmd_data  = ~d;
        if0.cmd_valid = 1'b1;
      end
      if (i == 4) if0.cmd_valid = 1'b0;
      @(negedge clk);
      if (if0.rsp_valid !== 1'b1 || if0.rsp_data !== e.data ||
          if0.rsp_ir_out !== e.ir || if0.cmd_ready !== 1'b0 ||
          tck0 !== 1'b0)
        ok = 1'b0;
    end
    n_vec++;
    if (ok !== 1'b1) begin
      n_err++;
      $display("FAIL bp_stable: got %b want 1", ok);
    end
    n_vec++;
    if (if0.rsp_data !== e.data) begin
      n_err++;
      $display("FAIL bp_data: got %h want %h", if0.rsp_data, e.data);
    end
    accept0();
    ok = 1'b1;
    repeat (6) begin
      if (if0.busy !== 1'b0 || tck0 !== 1'b0) ok = 1'b0;
      @(negedge clk);
    end
    n_vec++;
    if (ok !== 1'b1) begin
      n_err++;
      $display("FAIL bp_not_queued: got %b want 1", ok);
    end
  endtask

  task automatic test_fast();
    exp_t        e;
    int          lat;
    logic [37:0] d, p;
    d = {6'($urandom()), 32'($urandom())};
    p = {6'($urandom()), 32'($urandom())};
    issue1(2'b10, d, p, 2'b11, 89);
    await1(lat);
    e = sb1.pop_front();
    n_vec++;
    if (lat !== e.lat) begin
      n_err++;
      $display("FAIL fast_latency: got %0d want %0d", lat, e.lat);
    end
    n_vec++;
    if (if1.rsp_data !== e.data || if1.rsp_ir_out !== e.ir) begin
      n_err++;
      $display("FAIL fast_rsp: got %h/%b want %h/%b",
               if1.rsp_data, if1.rsp_ir_out, e.data, e.ir);
    end
    n_vec++;
    if (sr1 !== d || rise_sdr1 !== 38) begin
      n_err++;
      $display("FAIL fast_slave: sr=%h rises=%0d want %h 38",
               sr1, rise_sdr1, d);
    end
    n_vec++;
    if (per1 !== 2) begin
      n_err++;
      $display("FAIL fast_tck_period: got %0d want 2", per1);
    end
    n_vec++;
    if (rti_cnt1 !== 6) begin
      n_err++;
      $display("FAIL fast_rti_len: got %0d want 6", rti_cnt1);
    end
    n_vec++;
    if (bad1 !== 0) begin
      n_err++;
      $display("FAIL fast_one_hot: got %0d want 0", bad1);
    end
    accept1();
  endtask

  task automatic test_reset_mid();
    exp_t        e;
    int          lat;
    int          n;
    bit          seen;
    logic [37:0] d, p;
    d = {6'($urandom()), 32'($urandom())};
    p = {6'($urandom()), 32'($urandom())};
    issue0(2'b00, d, p, 2'b01, 169);
    n = 0;
    while (!(sdr0 && rise_sdr0 == 20) && n < 400) begin
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (n >= 400) begin
      n_err++;
      $display("FAIL mid_reach_20: got timeout want 20th rise");
    end
    rst0 = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({tck0, tdi0, irin0, uir0, cdr0, sdr0, udr0, rti0} !== 9'h0 ||
        if0.rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_vji: vji=%b v=%b want 0",
               {tck0, tdi0, irin0, uir0, cdr0, sdr0, udr0, rti0},
               if0.rsp_valid);
    end
    rst0 = 1'b0;
    void'(sb0.pop_back());
    seen = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (if0.rsp_valid) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0 || if0.cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL mid_no_rsp: seen=%b ready=%b want 0 1",
               seen, if0.cmd_ready);
    end
    d = {6'($urandom()), 32'($urandom())};
    p = {6'($urandom()), 32'($urandom())};
    issue0(2'b01, d, p, 2'b10, 169);
    await0(lat);
    e = sb0.pop_front();
    n_vec++;
    if (lat !== e.lat || if0.rsp_data !== e.data || sr0 !== d) begin
      n_err++;
      $display("FAIL mid_recover: lat=%0d data=%h sr=%h want %0d %h %h",
               lat, if0.rsp_data, sr0, e.lat, e.data, d);
    end
    accept0();
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    int          lat;
    logic [37:0] d, p;
    logic [1:0]  ir, irr;
    for (int k = 0; k < 3; k++) begin
      d   = {6'($urandom()), 32'($urandom())};
      p   = {6'($urandom()), 32'($urandom())};
      ir  = 2'($urandom());
      irr = 2'($urandom());
      n_vec++;
      if (if0.cmd_ready !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_ready[%0d]: got %b want 1", k, if0.cmd_ready);
      end
      issue0(ir, d, p, irr, 169);
      await0(lat);
      e = sb0.pop_front();
      n_vec++;
      if (lat !== e.lat || if0.rsp_data !== e.data ||
          if0.rsp_ir_out !== e.ir || irin0 !== ir) begin
        n_err++;
        $display("FAIL b2b[%0d]: lat=%0d d=%h ir=%b in=%b want %0d %h %b %b",
                 k, lat, if0.rsp_data, if0.rsp_ir_out, irin0,
                 e.lat, e.data, e.ir, ir);
      end
      accept0();
    end
  endtask

  initial begin
    if0.cmd_valid = 1'b0;
    if0.cmd_ir    = '0;
    if0.cmd_data  = '0;
    if0.rsp_ready = 1'b0;
    if1.cmd_valid = 1'b0;
    if1.cmd_ir    = '0;
    if1.cmd_data  = '0;
    if1.rsp_ready = 1'b0;
    pre0    = '0;
    pre1    = '0;
    irresp0 = '0;
    irresp1 = '0;
    rst0    = 1'b1;
    rst1    = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_fast();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_debug_slave_vjtag_master.md
Name: cpu_debug_slave_vjtag_master

Overview:
Initiator-side driver for the CPU debug slave's virtual-JTAG interface. It accepts one IR/DR command and runs the full virtual-JTAG scan: UIR, then CDR, then 38-bit SDR, then UDR, then RTI. It generates a divided TCK and returns the captured TDO word.
It sits between a system-clock command source (a test sequencer or host bridge) and the debug slave's vji_* port set, replacing the sld_virtual_jtag_basic hub in simulation and hub-less builds.

Parameters:
DR_WIDTH, 38, scan-chain length in bits.
IR_WIDTH, 2, virtual IR width.
TCK_HALF, 2, clk cycles per TCK half-period (must be at least 1).
RTI_CYCLES, 1, TCK periods spent in run-test-idle after UDR (must be at least 1).

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
cmd_valid  in  1  command request.
cmd_ready  out  1  high only in IDLE.
cmd_ir  in  IR_WIDTH  IR value to load.
cmd_data  in  DR_WIDTH  DR word to shift in, LSB first.
rsp_valid  out  1  response available.
rsp_ready  in  1  response accept.
rsp_data  out  DR_WIDTH  captured TDO word; first-shifted bit lands in bit 0.
rsp_ir_out  out  IR_WIDTH  vji_ir_out sampled during UIR.
busy  out  1  high in any state other than IDLE.
vji_tck  out  1  generated TCK.
vji_tdi  out  1  serial data to the slave.
vji_tdo  in  1  serial data from the slave.
vji_ir_in  out  IR_WIDTH  virtual IR.
vji_ir_out  in  IR_WIDTH  slave IR status.
vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  out  1 each  virtual state flags.

Behaviour:
- Reset values:
  - All outputs 0 except cmd_ready.
  - cmd_ready is 1 in the first cycle after reset deasserts.
  - Internal shift registers and phase counter are cleared.
- TCK generation:
  - In IDLE and RESP, TCK is held at 0.
  - Otherwise each TCK period is TCK_HALF clk cycles low followed by TCK_HALF clk cycles high.
  - The phase counter restarts at 0 (TCK low) on entry to UIR.
- Ticks:
  - Rise tick: the clk edge where TCK goes 0 to 1. vji_tdo is sampled here.
  - Fall tick: the clk edge where TCK goes 1 to 0. State, vji_tdi and the flag outputs update here.
- States: IDLE, UIR, CDR, SDR, UDR, RTI, RESP.
  - IDLE: on the cmd_valid and cmd_ready handshake, latch cmd_ir and cmd_data. Then go to UIR and load vji_ir_in with cmd_ir.
  - UIR: one TCK period, vji_uir=1. Sample vji_ir_out into rsp_ir_out on the rise tick.
  - CDR: one TCK period, vji_cdr=1.
  - SDR: DR_WIDTH periods, vji_sdr=1.
    - vji_tdi = current bit 0 of the TX shift register.
    - On each rise tick, rx shifts as {vji_tdo, rx[DR_WIDTH-1:1]}.
    - On each fall tick, tx shifts right. tdi is 0 outside SDR.
  - UDR: one TCK period, vji_udr=1.
  - RTI: RTI_CYCLES periods, vji_rti=1.
  - RESP: rsp_valid=1, with rsp_data and rsp_ir_out stable. On the rsp_ready handshake, go to IDLE on the next cycle.
- Flag outputs are registered. Exactly one of uir/cdr/sdr/udr/rti is high while scanning.
- vji_ir_in is sticky: it holds its value after the scan until the next UIR or reset.
- Latency: rsp_valid first rises 1 + N*2*TCK_HALF cycles after the command handshake cycle, where N = 3 + DR_WIDTH + RTI_CYCLES. With defaults N = 42, so latency is 169 cycles.
- Backpressure: while RESP is held, cmd_ready=0. A new command is accepted no earlier than the cycle after the response handshake.
- cmd_valid while busy is ignored; the command is not queued.
- Reset mid-scan (any state) takes effect the next cycle:
  - All vji outputs go to 0 and TCK goes low.
  - The partial response is discarded and no rsp_valid is produced.
  - The block returns to IDLE.

Decomposition:
- Package cpu_debug_vjtag_pkg holds:
  - the state enum;
  - DR_WIDTH and IR_WIDTH default constants;
  - IR opcode constants for the slave (OCIMEM=00, TRACEMEM=01, BREAK=10, TRACECTRL=11).
- Sub-module cpu_debug_slave_vjtag_tck_gen contains the phase counter, TCK output and the rise/fall tick strobes.
  - Its enable input is high outside IDLE and RESP.
  - Its counter restarts when enable is low.

Test Plan:
1. Reset, then release: all vji_* are 0 and rsp_valid=0. cmd_ready=1 on the first cycle after release and busy=0.
2. Slave model with a 38-bit sr preloaded to 38'h2A_5A5A_5A5A; send ir=01, data=38'h3F_0000_0001:
   - vji_ir_in=01 from UIR onward;
   - rsp_data=38'h2A_5A5A_5A5A and the model's sr ends at 38'h3F_0000_0001;
   - rsp_valid rises exactly 169 cycles after the handshake;
   - exactly 38 rise ticks occur with vji_sdr=1.
3. Model drives vji_ir_out=10 during UIR: rsp_ir_out=10. The value holds until the next command.
4. Hold rsp_ready=0 for 10 cycles in RESP: rsp_valid, rsp_data and rsp_ir_out stay stable, cmd_ready=0, and TCK stays 0. A cmd_valid pulse during that time is not accepted.
5. With TCK_HALF=1 and RTI_CYCLES=3: TCK period is 2 clk, vji_rti is high for 6 clk, and latency is 1+44*2 = 89 cycles.
6. Assert reset at the 20th SDR rise tick:
   - next cycle, all vji outputs and rsp_valid are 0;
   - no response appears within 200 cycles;
   - a following command completes with correct data.
